// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants, totals and region decode.
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int DEF_CW = 10;
  typedef enum logic [1:0] {REG_VISIBLE, REG_FRONT, REG_SYNC, REG_BACK} region_t;
  function automatic int axis_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction
  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  function automatic region_t region_of(input int p, input int vis, input int front, input int sync);
    return p < vis ? REG_VISIBLE : p < vis + front ? REG_FRONT : p < vis + front + sync ? REG_SYNC : REG_BACK;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: compare-and-wrap position counter with next-state region flags.
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT = DEF_H_FRONT,
  parameter int SYNC = DEF_H_SYNC
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  logic [CW-1:0] nxt;
  region_t r;
  // flags describe the position the counter is about to hold, so the top can register them in step
  always_comb begin
    wrap = en && (count == LAST);
    nxt = wrap ? '0 : count + CW'(en);
    r = region_of(int'(nxt), VISIBLE, FRONT, SYNC);
    active = r == REG_VISIBLE;
    sync = r == REG_SYNC;
  end
  always_ff @(posedge pixel_clk or negedge reset_n)
    if (!reset_n) count <= LAST;
    else count <= nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered raster timing; VGA_PIPE_ALIGN_EN delays hs/vs/blank one cycle.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter int CW = DEF_CW
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic [CW-1:0] draw_x,
  output logic [CW-1:0] draw_y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync, hs_r, vs_r, blank_r;
  vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC)) u_h (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(1'b1),
    .count(draw_x), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );
  vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC)) u_v (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(h_wrap),
    .count(draw_y), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );
  // v_wrap already implies h_wrap, so it alone marks the frame corner
  always_ff @(posedge pixel_clk or negedge reset_n)
    if (!reset_n) begin
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      blank_r <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_r <= ~h_sync;
      vs_r <= ~v_sync;
      blank_r <= h_act & v_act;
      line_start <= h_wrap;
      frame_start <= v_wrap;
    end
`ifdef VGA_PIPE_ALIGN_EN
  always_ff @(posedge pixel_clk or negedge reset_n)
    if (!reset_n) begin
      hs <= 1'b1;
      vs <= 1'b1;
      blank <= 1'b0;
    end else begin
      hs <= hs_r;
      vs <= vs_r;
      blank <= blank_r;
    end
`else
  assign hs = hs_r;
  assign vs = vs_r;
  assign blank = blank_r;
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the display path.
- Produces horizontal/vertical sync, the `blank` display-enable and pixel coordinates `draw_x`/`draw_y`, all coincident on every cycle.
- Feeds `blank` to the colour mapper, and `draw_x`/`draw_y` to the sprite/board renderer that generates IDX colour.
- Default mode: 640x480 at 60 Hz with a 25 MHz pixel clock.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CW, 10, counter/coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- pixel_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous reset, active-low
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  display enable; 1 = visible pixel, 0 = forces black downstream
- draw_x  out  CW  current pixel column
- draw_y  out  CW  current pixel row
- line_start  out  1  one-cycle pulse at draw_x==0
- frame_start  out  1  one-cycle pulse at draw_x==0 && draw_y==0

Behaviour:
- Totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800)
  - V_TOTAL likewise (default 525)
- Reset (async assert, sync release): all outputs are decoded for position (H_TOTAL-1, V_TOTAL-1):
  - draw_x=H_TOTAL-1, draw_y=V_TOTAL-1
  - hs=1, vs=1, blank=0, line_start=0, frame_start=0
- First rising edge after release moves to (0,0): blank=1, line_start=1, frame_start=1.
- Horizontal counter: increments every cycle; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the horizontal wrap; at V_TOTAL-1 (coincident with horizontal wrap) it wraps to 0.
- All outputs are registered. Compute them from next-state counter values so hs/vs/blank/pulses are exactly coincident with the registered draw_x/draw_y. Latency from counter to outputs is 0 cycles; no combinational outputs.
- Decode rules, with x = draw_x and y = draw_y:
  - blank = (x < H_VISIBLE) && (y < V_VISIBLE)
  - hs = 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (default 656..751)
  - vs = 0 iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for every x on those lines
- During blanking, draw_x/draw_y keep counting the true position, beyond the visible range. Consumers must gate on blank.
- Reset mid-frame: immediate return to reset values; the next frame restarts cleanly at (0,0) with frame_start=1. No partial-line artefacts are required to be suppressed.
- Arithmetic: unsigned CW-bit, compare-and-wrap only. The counter must never reach H_TOTAL or V_TOTAL.
- The vertical wrap and horizontal wrap in the same cycle produce frame_start and line_start together.

Optional Feature:
- Macro: VGA_PIPE_ALIGN_EN
- When defined:
  - hs, vs and blank pass through one extra register stage (reset values 1, 1, 0).
  - They then align with RGB registered one cycle later by the colour mapper.
  - draw_x, draw_y, line_start and frame_start stay undelayed, acting as the fetch-ahead position.
- When undefined: all outputs are coincident as above.

Decomposition:
- Package vga_timing_pkg holds:
  - default porch/sync/visible constants
  - H_TOTAL/V_TOTAL localparam functions
  - CW
  - an enum of region types (VISIBLE, FRONT, SYNC, BACK), used for the debug decode
- Natural sub-module: vga_axis_counter, instantiated twice (horizontal, vertical).
  - Inputs: enable, total, porch/sync bounds.
  - Outputs: count, wrap, active-region flag, sync-region flag.

Test Plan:
- Reset held 5 cycles, then released → outputs stay at (799,524) with hs=1, vs=1, blank=0; next edge gives (0,0), blank=1, frame_start=1, line_start=1.
- Run 1 line → blank=1 for x 0..639, 0 for 640..799; hs=0 exactly for x 656..751 (96 cycles); line_start period is 800 cycles.
- Run 1 full frame → frame_start period is exactly 420000 cycles; vs=0 for exactly 1600 cycles (y 490–491); blank=0 for all y>=480.
- Corner (799,524) → next cycle (0,0) with both pulses high; no out-of-range value (800 or 525) ever appears on draw_x/draw_y.
- Assert reset_n low at (300,200) asynchronously → outputs go to reset values without a clock edge; after release the sequence matches the first scenario.
- With VGA_PIPE_ALIGN_EN defined → the hs falling edge occurs one cycle after draw_x==656 and blank falls one cycle after draw_x==640; draw_x timing is unchanged from the undefined build.
